// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

    // Controller phases: waiting for a request, adding digits, reporting the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Largest legal BCD digit value.
    localparam logic [3:0] BCD_MAX  = 4'd9;

    // Added to a binary digit sum above 9 to skip the six unused codes.
    localparam logic [3:0] BCD_CORR = 4'd6;

    // True when a nibble holds a legal decimal digit.
    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle between the operand requester and the serial BCD adder.
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);

    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  invalid;

    // Requester side: presents operands and a start pulse, watches for done.
    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  sum,
        input  cout,
        input  invalid
    );

    // Adder side: consumes the request and drives the held result.
    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output sum,
        output cout,
        output invalid
    );

endinterface

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder; the controller time-shares a single instance across all digits.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] y;

    // Binary add five bits wide (max 19), then fold anything above 9 back into 0..9 with a carry.
    always_comb begin
        y = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (y > {1'b0, BCD_MAX}) begin
            sum  = y[3:0] + BCD_CORR;
            cout = 1'b1;
        end else begin
            sum  = y[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that processes one digit per clock, LSD first,
// rippling the decimal carry through a register instead of a combinational chain.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_serial_add_ctrl_if.slave   bus
);

    localparam int             IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);

    typedef logic [DIGITS-1:0][3:0] digits_t;

    state_t        state_q,   state_d;
    digits_t       a_q,       a_d;
    digits_t       b_q,       b_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic          carry_q,   carry_d;
    digits_t       sum_q,     sum_d;
    logic          cout_q,    cout_d;
    logic          invalid_q, invalid_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;

    digits_t       a_in;
    digits_t       b_in;
    logic          ops_valid;

    logic [3:0]    dig_a;
    logic [3:0]    dig_b;
    logic [3:0]    dig_sum;
    logic          dig_cout;

    assign a_in = bus.a;
    assign b_in = bus.b;

    // Operand screening happens on the raw inputs so the decision is ready on the start edge.
    always_comb begin
        ops_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(a_in[i]) || !is_bcd_digit(b_in[i])) begin
                ops_valid = 1'b0;
            end
        end
    end

    // The single shared digit adder sees whichever digit idx currently points at.
    assign dig_a = a_q[idx_q];
    assign dig_b = b_q[idx_q];

    bcd_digit_add u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    // Next-state and datapath decisions; busy/done are derived from the next state
    // so that both leave the flops cleanly aligned with the state they describe.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    carry_d   = bus.cin;
                    idx_d     = '0;
                    sum_d     = '0;
                    cout_d    = 1'b0;
                    invalid_d = ~ops_valid;
                    state_d   = ops_valid ? ADD : FIN;
                end
            end

            ADD: begin
                sum_d[idx_q] = dig_sum;
                carry_d      = dig_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_cout;
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ADD);
        done_d = (state_d == FIN);
    end

    // State and result registers; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign bus.invalid = invalid_q;

endmodule
